// File: rtl/xbar_spi_cfg.sv
// SPI mode-0 slave that receives 8-bit command frames and commits the crossbar
// control word and the SPI/GDS override selects for the downstream controller.
module xbar_spi_cfg #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] CFG_RESET   = 6'b100100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [5:0] cfg_out,
  output logic       spi_sel,
  output logic       gds_sel,
  output logic       cfg_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Handshake-free interface: cfg_valid is a single-clk strobe that marks the
  // cycle in which cfg_out/spi_sel/gds_sel take their newly committed values.

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sclk_d;
  logic                   cs_d;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       start_pend, start_pend_nxt;
  logic       miso_nxt;
  logic [5:0] cfg_nxt;
  logic       spi_nxt;
  logic       gds_nxt;
  logic       valid_nxt;
  logic       err_nxt;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // cs_n chain resets high so reset release never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sclk_d  <= sclk_sr[SYNC_STAGES-1];
      cs_d    <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      rx_shift   <= 8'd0;
      tx_shift   <= 8'd0;
      start_pend <= 1'b0;
      miso       <= 1'b0;
      cfg_out    <= CFG_RESET;
      spi_sel    <= 1'b0;
      gds_sel    <= 1'b0;
      cfg_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      rx_shift   <= rx_shift_nxt;
      tx_shift   <= tx_shift_nxt;
      start_pend <= start_pend_nxt;
      miso       <= miso_nxt;
      cfg_out    <= cfg_nxt;
      spi_sel    <= spi_nxt;
      gds_sel    <= gds_nxt;
      cfg_valid  <= valid_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    rx_shift_nxt   = rx_shift;
    tx_shift_nxt   = tx_shift;
    start_pend_nxt = start_pend;
    miso_nxt       = miso;
    cfg_nxt        = cfg_out;
    spi_nxt        = spi_sel;
    gds_nxt        = gds_sel;
    valid_nxt      = 1'b0;
    err_nxt        = err;

    case (state)
      IDLE: begin
        start_pend_nxt = 1'b0;
        if (cs_fall || start_pend) begin
          state_nxt    = SHIFT;
          bit_cnt_nxt  = 4'd0;
          rx_shift_nxt = 8'd0;
          tx_shift_nxt = {gds_sel, spi_sel, cfg_out};
          miso_nxt     = gds_sel;
        end
      end

      SHIFT: begin
        // A chip-select edge takes precedence over a coincident sclk edge.
        if (cs_rise) begin
          state_nxt = COMMIT;
        end else if (sclk_rise) begin
          rx_shift_nxt = {rx_shift[6:0], mosi_s};
          if (bit_cnt != 4'd9) bit_cnt_nxt = bit_cnt + 4'd1;
        end else if (sclk_fall) begin
          tx_shift_nxt = {tx_shift[6:0], 1'b0};
          miso_nxt     = tx_shift[6];
        end
      end

      COMMIT: begin
        state_nxt = IDLE;
        miso_nxt  = 1'b0;
        // A new frame starting during COMMIT is replayed from IDLE next cycle.
        if (cs_fall) start_pend_nxt = 1'b1;
        if (bit_cnt == 4'd8) begin
          case (rx_shift[7:6])
            2'b00: begin
              if (one_hot3(rx_shift[5:3]) && one_hot3(rx_shift[2:0])) begin
                cfg_nxt   = rx_shift[5:0];
                valid_nxt = 1'b1;
              end else begin
                err_nxt = 1'b1;
              end
            end
            2'b01: begin
              if (rx_shift[5:2] == 4'd0) begin
                gds_nxt   = rx_shift[1];
                spi_nxt   = rx_shift[0];
                valid_nxt = 1'b1;
              end else begin
                err_nxt = 1'b1;
              end
            end
            2'b10:   err_nxt = 1'b0;
            default: ;
          endcase
        end else begin
          err_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xbar_spi_cfg.sv
// Directed bench for xbar_spi_cfg: bit-banged SPI frames with hand-computed
// expected commits, select values, error flag, readback and strobe latency.
module tb_xbar_spi_cfg;
  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [5:0] cfg_out;
  logic       spi_sel;
  logic       gds_sel;
  logic       cfg_valid;
  logic       err;

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;

  xbar_spi_cfg #(.SYNC_STAGES(SYNC), .CFG_RESET(6'b100100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .cfg_out   (cfg_out),
    .spi_sel   (spi_sel),
    .gds_sel   (gds_sel),
    .cfg_valid (cfg_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_valid === 1'b1) valid_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not complete in time");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_clks(HALF);
    m    = miso;
    sclk = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] bits, input int n,
                           output logic [15:0] mbits, output int lat, output int pulses);
    int   v0;
    logic m;
    v0    = valid_cnt;
    mbits = '0;
    lat   = 0;
    cs_n  = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(bits[i], m);
      mbits = {mbits[14:0], m};
    end
    wait_clks(HALF);
    cs_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cfg_valid === 1'b1 && lat == 0) lat = k;
    end
    #1;
    pulses = valid_cnt - v0;
  endtask

  initial begin
    logic [15:0] mb;
    logic        m;
    int          lat;
    int          pulses;

    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(6);

    // 1: reset state with an idle bus
    check("rst_cfg", 16'(cfg_out), 16'h0024);
    check("rst_spi", 16'(spi_sel), 16'h0000);
    check("rst_gds", 16'(gds_sel), 16'h0000);
    check("rst_err", 16'(err), 16'h0000);
    check("rst_miso", 16'(miso), 16'h0000);
    check("rst_valid", 16'(cfg_valid), 16'h0000);

    // 2: valid cfg write, strobe latency, then readback via a nop frame
    spi_frame(16'h0011, 8, mb, lat, pulses);
    check("wr_cfg", 16'(cfg_out), 16'h0011);
    check("wr_pulses", 16'(pulses), 16'h0001);
    check("wr_latency", 16'(lat), 16'(SYNC + 2));
    check("wr_err", 16'(err), 16'h0000);
    spi_frame(16'h00C0, 8, mb, lat, pulses);
    check("rb_miso", mb, 16'h0011);
    check("nop_pulses", 16'(pulses), 16'h0000);
    check("nop_cfg", 16'(cfg_out), 16'h0011);

    // 3: non-one-hot input field rejected, then error clear
    spi_frame(16'h0019, 8, mb, lat, pulses);
    check("bad_cfg_err", 16'(err), 16'h0001);
    check("bad_cfg_keep", 16'(cfg_out), 16'h0011);
    check("bad_cfg_pulses", 16'(pulses), 16'h0000);
    spi_frame(16'h0080, 8, mb, lat, pulses);
    check("clr_err", 16'(err), 16'h0000);
    check("clr_pulses", 16'(pulses), 16'h0000);

    // 4: select write, then select write with reserved bits set
    spi_frame(16'h0042, 8, mb, lat, pulses);
    check("sel_gds", 16'(gds_sel), 16'h0001);
    check("sel_spi", 16'(spi_sel), 16'h0000);
    check("sel_pulses", 16'(pulses), 16'h0001);
    check("sel_latency", 16'(lat), 16'(SYNC + 2));
    check("sel_cfg_keep", 16'(cfg_out), 16'h0011);
    spi_frame(16'h0045, 8, mb, lat, pulses);
    check("bad_sel_err", 16'(err), 16'h0001);
    check("bad_sel_gds", 16'(gds_sel), 16'h0001);
    check("bad_sel_spi", 16'(spi_sel), 16'h0000);
    check("bad_sel_pulses", 16'(pulses), 16'h0000);

    // 5: short frame, overlong frame whose last 8 bits look valid, nop
    spi_frame(16'h0080, 8, mb, lat, pulses);
    check("clr2_err", 16'(err), 16'h0000);
    spi_frame(16'h0002, 5, mb, lat, pulses);
    check("short_err", 16'(err), 16'h0001);
    check("short_pulses", 16'(pulses), 16'h0000);
    check("short_cfg", 16'(cfg_out), 16'h0011);
    check("short_miso", mb, 16'h0012);
    spi_frame(16'h0080, 8, mb, lat, pulses);
    check("clr3_err", 16'(err), 16'h0000);
    spi_frame(16'h0321, 10, mb, lat, pulses);
    check("long_err", 16'(err), 16'h0001);
    check("long_pulses", 16'(pulses), 16'h0000);
    check("long_cfg", 16'(cfg_out), 16'h0011);
    spi_frame(16'h00C0, 8, mb, lat, pulses);
    check("nop2_err", 16'(err), 16'h0001);
    check("nop2_pulses", 16'(pulses), 16'h0000);
    check("nop2_cfg", 16'(cfg_out), 16'h0011);
    check("nop2_gds", 16'(gds_sel), 16'h0001);
    check("nop2_miso", mb, 16'h0091);

    // 6: asynchronous reset in the middle of a frame
    cs_n = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cfg", 16'(cfg_out), 16'h0024);
    check("mid_rst_spi", 16'(spi_sel), 16'h0000);
    check("mid_rst_gds", 16'(gds_sel), 16'h0000);
    check("mid_rst_err", 16'(err), 16'h0000);
    check("mid_rst_miso", 16'(miso), 16'h0000);
    check("mid_rst_valid", 16'(cfg_valid), 16'h0000);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(6);
    spi_frame(16'h000C, 8, mb, lat, pulses);
    check("post_rst_cfg", 16'(cfg_out), 16'h000C);
    check("post_rst_pulses", 16'(pulses), 16'h0001);
    check("post_rst_err", 16'(err), 16'h0000);
    check("post_rst_miso", mb, 16'h0024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
